// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier tail: resolver FSM states,
// default geometry and the chunk-count derivation.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int DEF_LENGTH = 128;
  localparam int DEF_CHUNK  = 32;

  function automatic int booth_nchunk(input int length, input int chunk);
    return (2 * length) / chunk;
  endfunction

endpackage

// File: rtl/booth_cpa_resolver_chunk.sv
// Combinational CHUNK-bit slice adder used by the sequential carry-propagate
// resolver; one instance is time-shared across all chunks.
module cpa_chunk #(
  parameter int CHUNK = 32
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};

endmodule

// File: rtl/booth_cpa_resolver.sv
// Resolves the redundant sum/carry rows of the Booth multiplier into a binary
// product, CHUNK bits per cycle with a registered inter-chunk carry.
module booth_cpa_resolver
  import booth_pkg::*;
#(
  parameter int LENGTH = DEF_LENGTH,
  parameter int CHUNK  = DEF_CHUNK
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*LENGTH:0]   in_sum,
  input  logic [2*LENGTH:0]   in_carry,
  input  logic                in_cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*LENGTH-1:0] out_prod,
  output logic                out_cout
);

  localparam int NCHUNK = booth_nchunk(LENGTH, CHUNK);
  localparam int PW     = 2 * LENGTH;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  state_t          r_state;
  logic [PW-1:0]   r_a;
  logic [PW-1:0]   r_b;
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic [PW-1:0]   r_prod;
  logic            r_cout;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_sum_chunk;
  logic             w_cout_chunk;
  logic             w_unused_bits;

  // The top sum bit and the two top carry bits fall outside the product modulus.
  assign w_unused_bits = ^{in_sum[PW], in_carry[PW:PW-1]};

  assign w_a_chunk = r_a[int'(r_idx)*CHUNK +: CHUNK];
  assign w_b_chunk = r_b[int'(r_idx)*CHUNK +: CHUNK];

  cpa_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .i_a    (w_a_chunk),
    .i_b    (w_b_chunk),
    .i_cin  (r_carry),
    .o_sum  (w_sum_chunk),
    .o_cout (w_cout_chunk)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_prod  <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= in_sum[PW-1:0];
            r_b     <= {in_carry[PW-2:0], 1'b0};
            r_carry <= in_cin;
            r_idx   <= '0;
            r_state <= ST_ADD;
          end
        end
        ST_ADD: begin
          r_prod[int'(r_idx)*CHUNK +: CHUNK] <= w_sum_chunk;
          r_carry <= w_cout_chunk;
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_cout_chunk;
            r_idx   <= '0;
            r_state <= ST_HOLD;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        ST_HOLD: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs decode registered state only.
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_HOLD);
  assign out_prod  = r_prod;
  assign out_cout  = r_cout;

endmodule
